// File: rtl/seg7_scan_drv.sv
// -----------------------------------------------------------------------------
// seg7_scan_drv
// Four-digit multiplexed 7-segment driver. It shows one digit per slot,
// SCAN_DIV clocks per slot, and the anodes stay off for the first GAP_CYC
// clocks of every slot so that the previous digit does not ghost. The digit
// value is captured once per frame, so a frame never shows a mix of two
// values. The driver also does leading-zero blanking, blinking per digit and
// a decimal point per digit.
//
// Ports
//   clk         clock
//   rst         asynchronous reset, active-low
//   en          1 = scanning; 0 = display dark, all internal state held
//   digits      four BCD digits, [3:0] = digit 0 (rightmost)
//   blank_lz    leading-zero blanking enable (live)
//   blink_mask  bit i blanks digit i during blink phase 1 (live)
//   dp_mask     bit i lights the decimal point of digit i (live)
//   an          anode selects, active-low, at most one low
//   seg         segments {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   frame_tick  one-cycle pulse after the slot index wraps 3 -> 0
// -----------------------------------------------------------------------------
module seg7_scan_drv #(
  parameter int SCAN_DIV  = 50000,
  parameter int GAP_CYC   = 8,
  parameter int BLINK_DIV = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic        blank_lz,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int            BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [15:0]   PCNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0]   GAP_LEN   = 16'(GAP_CYC);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIV - 1);

  logic [15:0]   pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_tick_q, frame_tick_d;

  // BCD to active-low {g,f,e,d,c,b,a}. Codes 10-15 are shown as a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Prescaler, slot index, frame capture and blink phase.
  always_comb begin
    pcnt_d       = pcnt_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    bcnt_d       = bcnt_q;
    blink_ph_d   = blink_ph_q;
    frame_tick_d = 1'b0;
    if (en) begin
      if (pcnt_q == PCNT_LAST) begin
        pcnt_d = '0;
        idx_d  = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          // Start of a new frame: capture the value for the whole frame.
          shadow_d     = digits;
          frame_tick_d = 1'b1;
          if (bcnt_q == BCNT_LAST) begin
            bcnt_d     = '0;
            blink_ph_d = ~blink_ph_q;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end else begin
        pcnt_d = pcnt_q + 16'd1;
      end
    end
  end

  // Decode every digit of the next-state shadow. The output stage then picks
  // one of them with idx_d, so the outputs change on the same edge as idx.
  logic [6:0] dig_seg [4];
  logic [3:0] dig_zero;
  logic [3:0] lz_blank;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dig
    assign dig_seg[gi]  = bcd_to_seg(shadow_d[gi*4 +: 4]);
    assign dig_zero[gi] = (shadow_d[gi*4 +: 4] == 4'd0);
  end

  // Zeros are blanked from the left, and only until the first non-zero
  // digit. Digit 0 is always shown, so a value of zero still displays "0".
  assign lz_blank[3] = blank_lz & dig_zero[3];
  for (genvar gi = 2; gi >= 1; gi--) begin : g_lz
    assign lz_blank[gi] = lz_blank[gi+1] & dig_zero[gi];
  end
  assign lz_blank[0] = 1'b0;

  logic in_gap;
  logic blinked;

  always_comb begin
    an_d    = 4'hF;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    in_gap  = (pcnt_d < GAP_LEN);
    blinked = blink_ph_d & blink_mask[idx_d];
    if (en && !in_gap) begin
      an_d = ~(4'b0001 << idx_d);
      // Blink blanks both the segments and dp. Leading-zero blanking only
      // blanks the segments, so "0.5" can still show its point.
      if (!blinked) begin
        if (!lz_blank[idx_d]) begin
          seg_d = dig_seg[idx_d];
        end
        dp_d = ~dp_mask[idx_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      bcnt_q       <= '0;
      blink_ph_q   <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      bcnt_q       <= bcnt_d;
      blink_ph_q   <= blink_ph_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_drv
// Directed bench for seg7_scan_drv with SCAN_DIV=4, GAP_CYC=1, BLINK_DIV=2.
// A slot is 4 clocks: one dark gap clock, then 3 lit clocks. A frame is
// 16 clocks. All outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_drv;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_drv #(
    .SCAN_DIV  (4),
    .GAP_CYC   (1),
    .BLINK_DIV (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits     (digits),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the falling edge at which frame_tick is high.
  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    chk({tag, "_tick_seen"}, 32'(seen), 32'd1);
  endtask

  // Called on the falling edge where frame_tick is high (slot 0, first gap
  // clock). Checks the 16 clocks of the frame. es[i] and edp[i] are the
  // expected seg and dp for slot i while it is lit.
  task automatic frame_check(input string tag, input logic [3:0][6:0] es, input logic [3:0] edp);
    int         slot;
    bit         lit;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edpv;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      slot = k / 4;
      lit  = (k % 4) != 0;
      ean  = lit ? ~(4'b0001 << slot) : 4'hF;
      eseg = lit ? es[slot] : 7'h7F;
      edpv = lit ? edp[slot] : 1'b1;
      chk($sformatf("%s_an%0d", tag, k), 32'(an), 32'(ean));
      chk($sformatf("%s_seg%0d", tag, k), 32'(seg), 32'(eseg));
      chk($sformatf("%s_dp%0d", tag, k), 32'(dp), 32'(edpv));
      chk($sformatf("%s_tick%0d", tag, k), 32'(frame_tick), (k == 0) ? 32'd1 : 32'd0);
    end
    $display("frame %s done, errors so far %0d", tag, n_err);
  endtask

  // Blink phase for the frames after ticks 5..8 (BLINK_DIV=2): 0,1,1,0.
  logic [3:0] blink_exp;

  initial begin
    rst        = 1'b0;
    en         = 1'b1;
    digits     = 16'h1234;
    blank_lz   = 1'b0;
    blink_mask = 4'b0000;
    dp_mask    = 4'b0000;
    blink_exp  = 4'b0110;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    $display("reset state checked");
    rst = 1'b1;

    // Basic scan of 1234 (frame after tick 1).
    wait_tick("basic");
    frame_check("basic", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);

    // Leading-zero blanking of 0070 (tick 2).
    digits   = 16'h0070;
    blank_lz = 1'b1;
    wait_tick("lz");
    frame_check("lz", {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'hF);

    // The shadow holds across a digits change mid-frame (ticks 3 and 4).
    digits   = 16'h0000;
    blank_lz = 1'b0;
    wait_tick("shadow_old");
    digits = 16'h00AB;
    frame_check("shadow_old", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);
    wait_tick("shadow_new");
    frame_check("shadow_new", {7'h40, 7'h40, 7'h3F, 7'h3F}, 4'hF);

    // Blink digit 0, dp on digit 1 (ticks 5..8).
    digits     = 16'h1234;
    blink_mask = 4'b0001;
    dp_mask    = 4'b0010;
    for (int f = 0; f < 4; f++) begin
      wait_tick($sformatf("blink%0d", f));
      frame_check($sformatf("blink%0d", f),
                  {7'h79, 7'h24, 7'h30, (blink_exp[f] ? 7'h7F : 7'h19)}, 4'b1101);
    end

    // Enable hold in the middle of slot 1.
    blink_mask = 4'b0000;
    dp_mask    = 4'b0000;
    wait_tick("en_hold");
    repeat (6) @(negedge clk);            // idx=1, pcnt=2
    chk("en_pre_an", 32'(an), 32'hD);
    chk("en_pre_seg", 32'(seg), 32'h30);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("en_off_an%0d", i), 32'(an), 32'hF);
      chk($sformatf("en_off_seg%0d", i), 32'(seg), 32'h7F);
      chk($sformatf("en_off_dp%0d", i), 32'(dp), 32'd1);
      chk($sformatf("en_off_tick%0d", i), 32'(frame_tick), 32'd0);
    end
    en = 1'b1;
    @(negedge clk);                       // idx=1, pcnt=3
    chk("en_res_an0", 32'(an), 32'hD);
    chk("en_res_seg0", 32'(seg), 32'h30);
    @(negedge clk);                       // idx=2, pcnt=0 (gap)
    chk("en_res_an1", 32'(an), 32'hF);
    @(negedge clk);                       // idx=2, pcnt=1
    chk("en_res_an2", 32'(an), 32'hB);
    chk("en_res_seg2", 32'(seg), 32'h24);
    $display("enable hold checked, errors so far %0d", n_err);

    // Asynchronous reset between two clock edges.
    #2 rst = 1'b0;
    #1;
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_dp", 32'(dp), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        chk($sformatf("arst_rel_an%0d", k), 32'(an), 32'hE);
        chk($sformatf("arst_rel_seg%0d", k), 32'(seg), 32'h40);
      end else if (k == 4) begin
        chk("arst_rel_an4", 32'(an), 32'hF);
      end else begin
        chk("arst_rel_an5", 32'(an), 32'hD);
      end
      chk($sformatf("arst_rel_tick%0d", k), 32'(frame_tick), 32'd0);
    end
    $display("async reset checked, errors so far %0d", n_err);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
